// File: rtl/spi_cc3000_slave_if.sv
// SPI bus between the fabric master and the CC3000-side slave responder.
// The slave modport is used by spi_cc3000_slave; the master modport is the
// fabric (or bench) end of the link.
interface spi_cc3000_slave_if;
  logic SPI_CLK;
  logic SPI_SS;
  logic SPI_DI;
  logic SPI_DO;
  logic SPI_DO_OE;
  logic IRQ_N;

  modport slave (
    input  SPI_CLK,
    input  SPI_SS,
    input  SPI_DI,
    output SPI_DO,
    output SPI_DO_OE,
    output IRQ_N
  );

  modport master (
    output SPI_CLK,
    output SPI_SS,
    output SPI_DI,
    input  SPI_DO,
    input  SPI_DO_OE,
    input  IRQ_N
  );
endinterface

// File: rtl/spi_cc3000_slave.sv
// SPI mode-1 slave responder modelling the CC3000 end of the fabric SPI link.
// MOSI bytes are deserialised into an rx_valid pulse stream, a one-entry
// holding register feeds MISO, and IRQ_N follows irq_req one cycle later.
// All SPI inputs are oversampled in the SYSCLK domain (SYNC_STAGES >= 2).
module spi_cc3000_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'h00,
  parameter int         CNT_W       = 16
) (
  input  logic                 SYSCLK,
  input  logic                 NSYSRESET,
  spi_cc3000_slave_if.slave    spi,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_underrun,
  output logic                 frame_active,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     byte_count,
  input  logic                 irq_req
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKOUT = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t state, state_next;

  // Synchroniser chains reset to 0 so that an SS held low through reset is
  // seen as "already low" (no false falling edge) and sends the FSM to LOCKOUT.
  logic [SYNC_STAGES-1:0] clk_sync, ss_sync, di_sync;
  logic clk_s, ss_s, di_s;
  logic clk_d, ss_d;
  logic clk_rise, clk_fall, ss_rise, ss_fall;

  logic       start_frame, end_frame, do_rise, do_fall;
  logic       byte_done, reload, bypass, tx_load, underrun;
  logic [7:0] next_byte;

  logic       hold_full;
  logic [7:0] hold_data;
  logic [7:0] shift_out;
  logic [6:0] shift_in;
  logic [2:0] bit_cnt;
  logic       do_q, oe_q, irq_n_q;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign ss_s  = ss_sync[SYNC_STAGES-1];
  assign di_s  = di_sync[SYNC_STAGES-1];

  assign clk_rise = clk_s & ~clk_d;
  assign clk_fall = ~clk_s & clk_d;
  assign ss_rise  = ss_s & ~ss_d;
  assign ss_fall  = ~ss_s & ss_d;

  assign tx_ready      = ~hold_full;
  assign spi.SPI_DO    = do_q;
  assign spi.SPI_DO_OE = oe_q;
  assign spi.IRQ_N     = irq_n_q;

  // Input synchronisers and one-cycle delayed copies for edge detection.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      clk_sync <= '0;
      ss_sync  <= '0;
      di_sync  <= '0;
      clk_d    <= 1'b0;
      ss_d     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi.SPI_CLK};
      ss_sync  <= {ss_sync[SYNC_STAGES-2:0], spi.SPI_SS};
      di_sync  <= {di_sync[SYNC_STAGES-2:0], spi.SPI_DI};
      clk_d    <= clk_s;
      ss_d     <= ss_s;
    end
  end

  // FSM state register.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) state <= IDLE;
    else            state <= state_next;
  end

  // FSM next state and per-cycle frame events; SPI clock edges only count in ACTIVE.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    do_rise     = 1'b0;
    do_fall     = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          start_frame = 1'b1;
          state_next  = ACTIVE;
        end else if (!ss_s) begin
          // SS low without a seen falling edge: only possible out of reset.
          state_next = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (ss_s) state_next = IDLE;
      end
      ACTIVE: begin
        do_rise = clk_rise;
        do_fall = clk_fall;
        if (ss_rise) begin
          end_frame  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte-boundary bookkeeping and selection of the next byte to shift out.
  // At frame start an offer arriving while the holding register is empty
  // goes straight to the shifter; a byte completing as SS rises does not
  // pull another byte since the frame is over.
  always_comb begin
    byte_done = do_fall && (bit_cnt == 3'd7);
    reload    = start_frame | (byte_done & ~end_frame);
    bypass    = start_frame & ~hold_full & tx_valid;
    tx_load   = tx_valid & ~hold_full & ~bypass;
    underrun  = reload & ~hold_full & ~bypass;
    if (hold_full)   next_byte = hold_data;
    else if (bypass) next_byte = tx_data;
    else             next_byte = IDLE_BYTE;
  end

  // One-entry TX holding register; a load in an unload cycle keeps the new byte.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (tx_load) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end else if (reload) begin
      hold_full <= 1'b0;
    end
  end

  // Shift datapath, frame status and output pulses.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      shift_out    <= 8'h00;
      shift_in     <= 7'h00;
      bit_cnt      <= 3'd0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      byte_count   <= '0;
      tx_underrun  <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      do_q         <= 1'b0;
      oe_q         <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_done  <= 1'b0;
      if (start_frame) begin
        bit_cnt      <= 3'd0;
        byte_count   <= '0;
        frame_active <= 1'b1;
        oe_q         <= 1'b1;
      end
      if (do_rise) begin
        do_q      <= shift_out[7];
        shift_out <= {shift_out[6:0], 1'b0};
      end
      if (do_fall) begin
        shift_in <= {shift_in[5:0], di_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_done) begin
          rx_data  <= {shift_in, di_s};
          rx_valid <= 1'b1;
          if (byte_count != {CNT_W{1'b1}}) byte_count <= byte_count + 1'b1;
        end
      end
      if (reload) begin
        shift_out   <= next_byte;
        tx_underrun <= underrun;
      end
      if (end_frame) begin
        oe_q         <= 1'b0;
        frame_active <= 1'b0;
        frame_done   <= 1'b1;
      end
    end
  end

  // IRQ line: registered inverse of the user request, independent of frames.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) irq_n_q <= 1'b1;
    else            irq_n_q <= ~irq_req;
  end

endmodule
